// File: rtl/maj_bist_ctrl.sv
// rtl/maj_bist_ctrl.sv - self-test sequencer and input owner for the 3-input majority gate
module maj_bist_ctrl #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] sw_in,
    output logic       maj_a,
    output logic       maj_b,
    output logic       maj_c,
    input  logic       maj_m,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic       fail_valid,
    output logic [2:0] fail_vec
);
    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] vec;
    logic [7:0] settle_cnt;
    logic [2:0] drive;
    logic       exp_m;
    logic       mismatch;
    logic       start_ok;

    assign exp_m    = (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);
    assign mismatch = (maj_m != exp_m);
    // start only counts outside a run
    assign start_ok = start && (state == IDLE || state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start_ok) state_nxt = SETTLE;
            SETTLE:     if (settle_cnt == 8'd0) state_nxt = CHECK;
            CHECK:      state_nxt = (vec == 3'd7) ? DONE : SETTLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            SETTLE, CHECK: busy = 1'b1;
            DONE:          done = 1'b1;
            default:       ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec        <= 3'd0;
            settle_cnt <= 8'd0;
            drive      <= 3'd0;
            err_count  <= 4'd0;
            fail_valid <= 1'b0;
            fail_vec   <= 3'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    drive <= sw_in;
                    if (start_ok) begin
                        vec        <= 3'd0;
                        drive      <= 3'd0;
                        settle_cnt <= SETTLE_LOAD;
                        err_count  <= 4'd0;
                        fail_valid <= 1'b0;
                        fail_vec   <= 3'd0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt != 8'd0) settle_cnt <= settle_cnt - 8'd1;
                end
                CHECK: begin
                    if (mismatch) begin
                        err_count <= err_count + 4'd1;
                        if (!fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_vec   <= vec;
                        end
                    end
                    if (vec == 3'd7) begin
                        drive <= sw_in;
                    end else begin
                        vec        <= vec + 3'd1;
                        drive      <= vec + 3'd1;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    assign {maj_a, maj_b, maj_c} = drive;
    assign pass = done && (err_count == 4'd0);
endmodule
